stream_mux_rr: RTL
==================

# stream_mux_rr

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes, selectable fixed-select or round-robin arbitration, and a one-entry output register. It generalises the team's 2:1 32-bit combinational data mux into a flow-controlled merge point. Its first use is the CPU's shared memory/writeback path, where several producers feed one consumer.

## Interface
- `WIDTH`, default 32: data width per channel.
- `CH`, default 4: channel count, 2..16. `SW = $clog2(CH)`.
- `CLK` in 1: sole clock, rising edge.
- `RST_N` in 1: synchronous, active-low reset.
- `MODE` in 1: arbitration mode. 0 = fixed select by `SEL`; 1 = round-robin.
- `SEL` in SW: channel index used when `MODE`=0. Values ≥ CH mean no grant.
- `IN_VALID` in CH: per-channel valid.
- `IN_DATA` in CH*WIDTH: channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `IN_READY` out CH: per-channel ready. One-hot or zero.
- `OUT_VALID` out 1: output register holds a beat.
- `OUT_DATA` out WIDTH: registered data.
- `OUT_CH` out SW: source channel of `OUT_DATA`.
- `OUT_READY` in 1: consumer accepts the beat.
- `IN_LAST` in CH: last beat of a packet. Present only with `STREAM_MUX_LOCK_EN`.

## Operation
- **Transfer rule:** a transfer occurs on a port when valid and ready are both high at a `CLK` edge.
- **Register state:** `can_load = !OUT_VALID || OUT_READY`.
- **Grant, MODE=0:** grant `g = SEL` if `SEL < CH` and `IN_VALID[SEL]`; otherwise no grant.
- **Grant, MODE=1:** `g` is the first k with `IN_VALID[k]`, searched cyclically from `ptr+1` mod CH. No grant if none is valid.
- **Ready:** `IN_READY[g] = can_load`. All other `IN_READY` bits are 0.
- **Load:** on an input transfer, `OUT_DATA <= IN_DATA[g]`, `OUT_CH <= g`, `OUT_VALID <= 1`.
- **Drain:** on an output transfer with no input transfer, `OUT_VALID <= 0`. `OUT_DATA` and `OUT_CH` hold their values.
- **Round-robin pointer `ptr`:** updates to `g` on every input transfer in either mode, so round-robin resumes fairly after a mode switch. Wrap: after `CH-1`, the search starts at 0.
- **Mode changes:** a change of `MODE` or `SEL` takes effect on the next arbitration. A beat already in the register is unaffected.
- **Stall:** when `OUT_VALID`=1 and `OUT_READY`=0, all `IN_READY`=0 and the register holds.
- **Reset (`RST_N`=0 at an edge):**
  - `OUT_VALID`=0, `OUT_DATA`=0, `OUT_CH`=0, `ptr`=CH-1 (so channel 0 wins first).
  - Lock is cleared.
  - While `RST_N`=0, `IN_READY`=0.
  - A beat in flight when reset asserts is discarded.

## Timing
- Latency is 1 cycle from input transfer to `OUT_VALID`.
- Throughput is 1 beat per cycle sustained while `OUT_READY`=1.
- `IN_READY` depends combinationally on `OUT_READY`, `IN_VALID`, `MODE`, `SEL`, and the lock state.
- `OUT_*` are register outputs with no combinational input-to-output path.
- Simultaneous load and drain in the same cycle produces no bubble.

## Configuration
- **`STREAM_MUX_LOCK_EN` defined:**
  - Adds the `IN_LAST` port and a lock flag with a locked channel `lk`.
  - An input transfer with `IN_LAST[g]`=0 sets the lock to `lk=g`.
  - While locked, `g = lk` regardless of `MODE`, `SEL`, or other valids. If `IN_VALID[lk]`=0, there is no grant.
  - A transfer with `IN_LAST[lk]`=1 clears the lock.
  - In MODE=1, `ptr` updates only on transfers where `IN_LAST[g]`=1.
- **`STREAM_MUX_LOCK_EN` not defined:** every beat is arbitrated independently, and there is no `IN_LAST` port.

## Structure
- Shared package `stream_pkg`:
  - `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1 constants.
  - A `ch_idx_t` width helper.
- Sub-module `rr_pick` is the natural split. It is combinational: `req[CH]` and `ptr` in, `gnt_idx` and `gnt_vld` out.
- The top level holds the output register, `ptr`, the lock flag, and the mode mux.

## Test plan
1. **Reset output:** hold `RST_N`=0 for 2 cycles with `IN_VALID`=4'b1111 → `OUT_VALID`=0, `OUT_DATA`=0, `IN_READY`=0. On the first cycle after release (MODE=1) → `IN_READY`=4'b0001.
2. **Round-robin fairness:** MODE=1, `IN_VALID`=4'b1111, `IN_DATA[k]`=32'hA000_000k, `OUT_READY`=1 → `OUT_CH` sequence 0,1,2,3,0 with no bubbles. `OUT_DATA` = 32'hA0000000, …, 32'hA0000003.
3. **Fixed select and invalid index:** MODE=0, CH=3, `SEL`=2, `IN_VALID`=3'b101 → grant channel 2, one beat out with `OUT_CH`=2. Then `SEL`=3 → `IN_READY`=0 and no further beats.
4. **Backpressure:** `OUT_READY`=0 for 3 cycles while `OUT_VALID`=1 → `OUT_DATA` holds and `IN_READY`=0. On re-assertion, load and drain occur in the same cycle, and `OUT_VALID` stays 1.
5. **Lock (macro on):** channel 1 sends 3 beats with `IN_LAST`=0,0,1 while channel 2 is valid → `OUT_CH`=1,1,1, then 2. Toggling `SEL` or `MODE` mid-packet has no effect.
6. **Mid-operation reset:** assert `RST_N`=0 with `OUT_VALID`=1 and the lock held → next cycle `OUT_VALID`=0, lock cleared, and channel 0 is granted first after release.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg: constants and helpers shared by the stream merge blocks.
//   MODE_FIXED / MODE_RR : encodings of the MODE arbitration input
//   CH_MAX / ch_idx_t    : widest channel index the merge blocks support
//   sel_in_range()       : true when a select value names an existing channel
package stream_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int CH_MAX = 16;

  // Channel index wide enough for the largest supported channel count.
  typedef logic [$clog2(CH_MAX)-1:0] ch_idx_t;

  // A select value is only a real channel when it is below the channel count.
  function automatic logic sel_in_range(input ch_idx_t sel, input int ch);
    return (int'(sel) < ch);
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches req cyclically starting one position past ptr and returns the first
// requesting index.
//   req     [CH]  in  : per-channel request
//   ptr     [SW]  in  : last granted channel (search starts at ptr+1 mod CH)
//   gnt_idx [SW]  out : chosen channel (0 when gnt_vld=0)
//   gnt_vld       out : some channel was requesting
module rr_pick #(
  parameter  int CH = 4,
  localparam int SW = $clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // One extra bit so ptr+i (at most 2*CH-1) never overflows before the wrap.
  logic [SW:0] cand_s;
  logic        hit_s;

  // cyclic first-match search; later candidates are masked once one hits
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int i = 1; i <= CH; i++) begin
      cand_s  = {1'b0, ptr} + (SW+1)'(i);
      cand_s  = (cand_s >= (SW+1)'(CH)) ? (cand_s - (SW+1)'(CH)) : cand_s;
      hit_s   = req[cand_s[SW-1:0]] && !gnt_vld;
      gnt_vld = gnt_vld | hit_s;
      gnt_idx = hit_s ? cand_s[SW-1:0] : gnt_idx;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: CH-input, WIDTH-bit flow-controlled merge point with a
// one-entry output register. Arbitration is either a fixed select (MODE=0,
// channel SEL) or round-robin (MODE=1).
// Optional feature macro: STREAM_MUX_LOCK_EN adds IN_LAST and holds the grant
// on one channel until the last beat of its packet has been taken.
//   CLK, RST_N          : clock and synchronous active-low reset
//   MODE, SEL           : arbitration mode and fixed-select channel
//   IN_VALID/IN_READY   : per-channel handshake, IN_READY is one-hot or zero
//   IN_DATA             : channel k in bits [k*WIDTH +: WIDTH]
//   IN_LAST             : packet end marker (STREAM_MUX_LOCK_EN only)
//   OUT_VALID/OUT_READY : output handshake
//   OUT_DATA, OUT_CH    : registered beat and the channel it came from
module stream_mux_rr
  import stream_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int CH    = 4,
  localparam int SW    = $clog2(CH)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                MODE,
  input  logic [SW-1:0]       SEL,
  input  logic [CH-1:0]       IN_VALID,
  input  logic [CH*WIDTH-1:0] IN_DATA,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [CH-1:0]       IN_LAST,
`endif
  output logic [CH-1:0]       IN_READY,
  output logic                OUT_VALID,
  output logic [WIDTH-1:0]    OUT_DATA,
  output logic [SW-1:0]       OUT_CH,
  input  logic                OUT_READY
);

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SW-1:0]    out_ch_r;
  logic [SW-1:0]    ptr_r;

  logic [SW-1:0]    rr_idx_s;
  logic             rr_vld_s;
  logic             sel_ok_s;
  logic [SW-1:0]    gnt_s;
  logic             gnt_vld_s;
  logic             can_load_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             ptr_upd_s;
  logic [WIDTH-1:0] gnt_data_s;

`ifdef STREAM_MUX_LOCK_EN
  logic             lock_r;
  logic [SW-1:0]    lk_r;
  logic             gnt_last_s;
`endif

  rr_pick #(
    .CH (CH)
  ) u_rr_pick (
    .req     (IN_VALID),
    .ptr     (ptr_r),
    .gnt_idx (rr_idx_s),
    .gnt_vld (rr_vld_s)
  );

  assign sel_ok_s = sel_in_range(ch_idx_t'(SEL), CH);

  // Register can take a beat when empty or being drained; nothing is
  // accepted while reset is held so a reset cycle never swallows a beat.
  assign can_load_s = RST_N && (!out_valid_r || OUT_READY);
  assign in_xfer_s  = gnt_vld_s && can_load_s;
  assign out_xfer_s = out_valid_r && OUT_READY;

  // grant selection: lock overrides mode, then fixed select or round-robin
  always_comb begin
    gnt_s     = '0;
    gnt_vld_s = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    if (lock_r) begin
      gnt_s     = lk_r;
      gnt_vld_s = IN_VALID[lk_r];
    end else begin
`endif
      case (MODE)
        MODE_FIXED: begin
          if (sel_ok_s) begin
            gnt_s     = SEL;
            gnt_vld_s = IN_VALID[SEL];
          end else begin
            gnt_s     = '0;
            gnt_vld_s = 1'b0;
          end
        end
        MODE_RR: begin
          gnt_s     = rr_idx_s;
          gnt_vld_s = rr_vld_s;
        end
        default: begin
          gnt_s     = '0;
          gnt_vld_s = 1'b0;
        end
      endcase
`ifdef STREAM_MUX_LOCK_EN
    end
`endif
  end

  // one-hot ready and AND-OR data mux for the granted channel
  always_comb begin
    IN_READY   = '0;
    gnt_data_s = '0;
    for (int k = 0; k < CH; k++) begin
      IN_READY[k] = in_xfer_s && (gnt_s == SW'(k));
      gnt_data_s  = gnt_data_s |
                    ({WIDTH{gnt_s == SW'(k)}} & IN_DATA[k*WIDTH +: WIDTH]);
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  assign gnt_last_s = IN_LAST[gnt_s];
  // Round-robin only advances at packet boundaries so a locked packet does
  // not cost its channel a turn; fixed mode tracks every transfer.
  assign ptr_upd_s  = in_xfer_s && ((MODE == MODE_FIXED) || gnt_last_s);
`else
  // Pointer follows every accepted beat in both modes so round-robin
  // resumes after the most recently served channel following a mode switch.
  assign ptr_upd_s  = in_xfer_s;
`endif

  // output register and round-robin pointer
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      ptr_r       <= SW'(CH-1);
    end else begin
      if (in_xfer_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= gnt_data_s;
        out_ch_r    <= gnt_s;
      end else if (out_xfer_s) begin
        out_valid_r <= 1'b0;
      end
      if (ptr_upd_s) begin
        ptr_r <= gnt_s;
      end
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  // packet lock: held from a non-last beat until the channel's last beat
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lock_r <= 1'b0;
      lk_r   <= '0;
    end else if (in_xfer_s) begin
      lock_r <= !gnt_last_s;
      lk_r   <= gnt_s;
    end
  end
`endif

  assign OUT_VALID = out_valid_r;
  assign OUT_DATA  = out_data_r;
  assign OUT_CH    = out_ch_r;

endmodule
